// File: rtl/cc_receive.sv
// cc_receive: 8N1 deserialiser for the CC link.
// Takes the byte stream from the CC transmitter (start low, 8 data bits LSB
// first, stop high). Each good byte is written into the frame buffer at
// consecutive addresses. frame_done flags a complete frame of SUBFRAME bytes.
// frame_err flags an aborted frame, either a bad stop bit or an idle gap
// inside a partial frame.
// Build options:
//   CC_RX_GLITCH_FILTER_EN - majority-of-three sampling around each sample
//                            point. The write comes one cycle later.
//   CFDR                   - selects the 2048-byte frame size.
module cc_receive #(
`ifdef CFDR
   parameter int SUBFRAME    = 2048,
`else
   parameter int SUBFRAME    = 48,
`endif
   parameter int BIT_PERIOD  = 51,
   parameter int GAP_TIMEOUT = 400
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx,
   output logic [11:0] wraddress,
   output logic [7:0]  wdata,
   output logic        wren,
   output logic        frame_done,
   output logic        frame_err,
   output logic [12:0] byte_count
);

   localparam int CW = $clog2(BIT_PERIOD + 1);
   localparam int GW = $clog2(GAP_TIMEOUT + 1);

`ifdef CC_RX_GLITCH_FILTER_EN
   // Decisions are taken one cycle after the nominal sample point.
   localparam int FILT_DLY = 1;
`else
   localparam int FILT_DLY = 0;
`endif

   localparam logic [CW-1:0] START_LAST = CW'(BIT_PERIOD / 2 - 1 + FILT_DLY);
   localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TIMEOUT - 1);
   localparam logic [12:0]   SUB13      = 13'(SUBFRAME);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    bit_idx_reg;
   logic [7:0]    shift_reg;
   logic [GW-1:0] gap_reg;
   logic          rx_meta_reg;
   logic          rx_s;
   logic          rx_s_d;
   logic          rx_bit;
   logic          fall;
   logic          timeout;

   // Two-flop synchroniser plus one history tap used for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_reg <= 1'b1;
         rx_s        <= 1'b1;
         rx_s_d      <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_s        <= rx_meta_reg;
         rx_s_d      <= rx_s;
      end
   end

   assign fall = rx_s_d & ~rx_s;

`ifdef CC_RX_GLITCH_FILTER_EN
   logic rx_s_d2;

   // Second history tap: together with rx_s_d and rx_s this gives the
   // -1, 0 and +1 samples around the nominal sample point.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rx_s_d2 <= 1'b1;
      else          rx_s_d2 <= rx_s_d;
   end

   assign rx_bit = (rx_s & rx_s_d) | (rx_s & rx_s_d2) | (rx_s_d & rx_s_d2);
`else
   assign rx_bit = rx_s;
`endif

   // An idle gap inside a partial frame aborts the frame. This check takes
   // priority over a start edge that arrives in the same cycle.
   assign timeout = (byte_count != 13'd0) && (byte_count != SUB13) &&
                    (gap_reg == GAP_LAST);

   // Receive FSM. All outputs are registered. The pulses default low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         gap_reg     <= '0;
         wraddress   <= '0;
         wdata       <= '0;
         wren        <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         byte_count  <= '0;
      end else begin
         wren       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (timeout) begin
                  frame_err  <= 1'b1;
                  byte_count <= '0;
                  wraddress  <= '0;
                  gap_reg    <= '0;
               end else begin
                  // The cycle after the last write of a frame rewinds to address 0.
                  if (byte_count == SUB13) begin
                     byte_count <= '0;
                     wraddress  <= '0;
                  end
                  if (fall) begin
                     state_reg   <= START;
                     cnt_reg     <= '0;
                     bit_idx_reg <= '0;
                     gap_reg     <= '0;
                  end else if (byte_count != 13'd0 && byte_count != SUB13) begin
                     gap_reg <= gap_reg + 1'b1;
                  end else begin
                     gap_reg <= '0;
                  end
               end
            end
            START: begin
               if (cnt_reg == START_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= rx_bit ? IDLE : DATA;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DATA: begin
               if (cnt_reg == BIT_LAST) begin
                  cnt_reg   <= '0;
                  shift_reg <= {rx_bit, shift_reg[7:1]};
                  if (bit_idx_reg == 3'd7) state_reg <= STOP;
                  else                     bit_idx_reg <= bit_idx_reg + 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            STOP: begin
               if (cnt_reg == BIT_LAST) begin
                  cnt_reg <= '0;
                  gap_reg <= '0;
                  if (rx_bit) begin
                     wren       <= 1'b1;
                     wdata      <= shift_reg;
                     wraddress  <= byte_count[11:0];
                     byte_count <= byte_count + 1'b1;
                     frame_done <= (byte_count + 13'd1 == SUB13);
                     state_reg  <= IDLE;
                  end else begin
                     frame_err  <= 1'b1;
                     byte_count <= '0;
                     wraddress  <= '0;
                     state_reg  <= WAIT_HIGH;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            WAIT_HIGH: begin
               if (rx_s) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cc_receive.sv
// tb_cc_receive: randomized self-checking bench for cc_receive.
// A behavioural model records each byte sent, with the address and the
// frame-done flag it should produce. A negedge monitor collects what the
// DUT actually wrote.
module tb_cc_receive;

   localparam int SUBFRAME = 48;
   localparam int BP       = 51;
   localparam int GAP      = 400;

   typedef struct packed {
      logic        done;
      logic [11:0] addr;
      logic [7:0]  data;
      logic [12:0] cnt;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic [11:0] wraddress;
   logic [7:0]  wdata;
   logic        wren;
   logic        frame_done;
   logic        frame_err;
   logic [12:0] byte_count;

   int checks = 0;
   int errors = 0;
   int mcount = 0;       // model: bytes accepted in current frame
   int exp_err = 0;      // model: frame_err pulses expected so far
   int obs_err = 0;      // monitor: frame_err pulses seen
   int orphan_done = 0;  // monitor: frame_done without wren
   wr_t exp_q[$];
   wr_t obs_q[$];
   wr_t mon_r;

   cc_receive #(
      .SUBFRAME(SUBFRAME),
      .BIT_PERIOD(BP),
      .GAP_TIMEOUT(GAP)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .rx(rx),
      .wraddress(wraddress),
      .wdata(wdata),
      .wren(wren),
      .frame_done(frame_done),
      .frame_err(frame_err),
      .byte_count(byte_count)
   );

   always #5 clock = ~clock;

   // Monitor: capture writes and pulses away from the active edge.
   always @(negedge clock) begin
      if (reset_n) begin
         if (wren) begin
            mon_r.done = frame_done;
            mon_r.addr = wraddress;
            mon_r.data = wdata;
            mon_r.cnt  = byte_count;
            obs_q.push_back(mon_r);
         end else if (frame_done) begin
            orphan_done++;
         end
         if (frame_err) obs_err++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Drive one 8N1 character. glitch_bit >= 0 inverts the line for one
   // cycle at the nominal sample point of that data bit. After a good stop
   // bit the line idles high for 'gap' cycles. After a bad stop bit it stays
   // low for 'gap' cycles, then returns high.
   task automatic send_byte(input logic [7:0] data, input bit stop_ok,
                            input int glitch_bit, input int gap);
      wr_t e;
      rx = 1'b0;
      tick(BP);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         if (i == glitch_bit) begin
            tick(26);
            rx = ~data[i];
            tick(1);
            rx = data[i];
            tick(BP - 27);
         end else begin
            tick(BP);
         end
      end
      rx = stop_ok;
      tick(BP);
      if (stop_ok) begin
         e.addr = 12'(mcount);
         e.data = data;
         mcount++;
         e.cnt  = 13'(mcount);
         e.done = (mcount == SUBFRAME);
         exp_q.push_back(e);
         if (e.done) mcount = 0;
         tick(gap);
      end else begin
         mcount = 0;
         exp_err++;
         tick(gap);
         rx = 1'b1;
         tick(8);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(3);
      obs_q.delete();
      exp_q.delete();
      mcount = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      tick(3);
      checks++;
      if ({wraddress, wdata, wren, frame_done, frame_err, byte_count} !== 36'd0) begin
         errors++;
         $display("FAIL reset_state: got addr=%0d data=%02h wren=%b done=%b err=%b cnt=%0d, need all zero",
                  wraddress, wdata, wren, frame_done, frame_err, byte_count);
      end
      reset_n = 1'b1;
      tick(5);
      checks++;
      if ({wraddress, wdata, wren, frame_done, frame_err, byte_count} !== 36'd0) begin
         errors++;
         $display("FAIL post_reset_idle: got addr=%0d data=%02h wren=%b cnt=%0d, need all zero",
                  wraddress, wdata, wren, byte_count);
      end
      $display("reset checked");
   endtask

   task automatic test_single();
      wr_t e, o;
      int err0 = obs_err;
      send_byte(8'hA5, 1'b1, -1, 20);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL single_write: got no write, need addr=%0d data=%02h", e.addr, e.data);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL single_write: got done=%b addr=%0d data=%02h cnt=%0d, need done=%b addr=%0d data=%02h cnt=%0d",
                        o.done, o.addr, o.data, o.cnt, e.done, e.addr, e.data, e.cnt);
            end else $display("single write addr=%0d data=%02h ok", o.addr, o.data);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL single_extra: got %0d extra writes, need 0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (byte_count !== 13'd1 || obs_err != err0) begin
         errors++;
         $display("FAIL single_count: got cnt=%0d errs=%0d, need cnt=1 errs=0", byte_count, obs_err - err0);
      end
   endtask

   task automatic test_glitch();
      wr_t e, o;
      int err0 = obs_err;
      rx = 1'b0;
      tick(10);
      rx = 1'b1;
      tick(80);
      checks++;
      if (obs_q.size() != 0 || obs_err != err0 || byte_count !== 13'(mcount)) begin
         errors++;
         $display("FAIL idle_glitch: got writes=%0d errs=%0d cnt=%0d, need writes=0 errs=0 cnt=%0d",
                  obs_q.size(), obs_err - err0, byte_count, mcount);
         obs_q.delete();
      end else $display("idle glitch ignored cnt=%0d", byte_count);
      send_byte(8'($urandom), 1'b1, -1, 20);
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
         errors++;
         $display("FAIL after_glitch: got no write, need addr=%0d data=%02h", e.addr, e.data);
      end else begin
         o = obs_q.pop_front();
         if (o !== e) begin
            errors++;
            $display("FAIL after_glitch: got addr=%0d data=%02h cnt=%0d, need addr=%0d data=%02h cnt=%0d",
                     o.addr, o.data, o.cnt, e.addr, e.data, e.cnt);
         end else $display("post-glitch write addr=%0d data=%02h ok", o.addr, o.data);
      end
   endtask

   task automatic test_frame();
      wr_t e, o;
      do_reset();
      for (int i = 0; i < SUBFRAME; i++) send_byte(8'(i), 1'b1, -1, 46);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL frame_write: got no write, need addr=%0d data=%02h", e.addr, e.data);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL frame_write: got done=%b addr=%0d data=%02h cnt=%0d, need done=%b addr=%0d data=%02h cnt=%0d",
                        o.done, o.addr, o.data, o.cnt, e.done, e.addr, e.data, e.cnt);
            end else $display("frame write addr=%0d data=%02h done=%b ok", o.addr, o.data, o.done);
         end
      end
      checks++;
      if (obs_q.size() != 0 || orphan_done != 0) begin
         errors++;
         $display("FAIL frame_extra: got extra=%0d stray_done=%0d, need 0 and 0", obs_q.size(), orphan_done);
         obs_q.delete();
      end
      checks++;
      if (byte_count !== 13'd0 || wraddress !== 12'd0) begin
         errors++;
         $display("FAIL frame_rewind: got cnt=%0d addr=%0d, need 0 and 0", byte_count, wraddress);
      end
   endtask

   task automatic test_framing_err();
      wr_t e, o;
      int err0 = obs_err;
      int exp0 = exp_err;
      send_byte(8'($urandom), 1'b1, -1, 20);
      send_byte(8'h3C, 1'b0, -1, 300);
      checks++;
      if (obs_err - err0 != exp_err - exp0 || byte_count !== 13'd0 || wraddress !== 12'd0) begin
         errors++;
         $display("FAIL framing_err: got errs=%0d cnt=%0d addr=%0d, need errs=%0d cnt=0 addr=0",
                  obs_err - err0, byte_count, wraddress, exp_err - exp0);
      end else $display("framing error flagged");
      send_byte(8'h11, 1'b1, -1, 20);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL framing_write: got no write, need addr=%0d data=%02h", e.addr, e.data);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL framing_write: got addr=%0d data=%02h cnt=%0d, need addr=%0d data=%02h cnt=%0d",
                        o.addr, o.data, o.cnt, e.addr, e.data, e.cnt);
            end else $display("write addr=%0d data=%02h ok", o.addr, o.data);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL framing_extra: got %0d extra writes, need 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_timeout();
      wr_t e, o;
      int err0 = obs_err;
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, -1, $urandom_range(0, 40));
      tick(300);
      checks++;
      if (obs_err != err0 || byte_count !== 13'(mcount)) begin
         errors++;
         $display("FAIL timeout_early: got errs=%0d cnt=%0d, need errs=0 cnt=%0d", obs_err - err0, byte_count, mcount);
      end
      tick(150);
      mcount = 0;
      checks++;
      if (obs_err != err0 + 1 || byte_count !== 13'd0 || wraddress !== 12'd0) begin
         errors++;
         $display("FAIL timeout_abort: got errs=%0d cnt=%0d addr=%0d, need errs=1 cnt=0 addr=0",
                  obs_err - err0, byte_count, wraddress);
      end else $display("gap timeout flagged");
      send_byte(8'($urandom), 1'b1, -1, 20);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL timeout_write: got no write, need addr=%0d data=%02h", e.addr, e.data);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL timeout_write: got addr=%0d data=%02h cnt=%0d, need addr=%0d data=%02h cnt=%0d",
                        o.addr, o.data, o.cnt, e.addr, e.data, e.cnt);
            end else $display("write addr=%0d data=%02h ok", o.addr, o.data);
         end
      end
   endtask

   task automatic test_reset_mid_byte();
      wr_t e, o;
      logic [7:0] v;
      int gb;
      v = 8'h7E;
`ifdef CC_RX_GLITCH_FILTER_EN
      gb = 3;
`else
      gb = -1;
`endif
      send_byte(8'hC3, 1'b1, -1, 20);
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
         errors++;
         $display("FAIL premid_write: got no write, need addr=%0d data=c3", e.addr);
      end else begin
         o = obs_q.pop_front();
         if (o !== e) begin
            errors++;
            $display("FAIL premid_write: got addr=%0d data=%02h, need addr=%0d data=%02h", o.addr, o.data, e.addr, e.data);
         end else $display("write addr=%0d data=%02h ok", o.addr, o.data);
      end
      rx = 1'b0;
      tick(BP);
      for (int i = 0; i < 3; i++) begin
         rx = v[i];
         tick(BP);
      end
      rx = v[3];
      tick(20);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({wraddress, wdata, wren, frame_done, frame_err, byte_count} !== 36'd0) begin
         errors++;
         $display("FAIL async_reset: got addr=%0d data=%02h wren=%b cnt=%0d, need all zero",
                  wraddress, wdata, wren, byte_count);
      end else $display("async reset cleared outputs");
      tick(3);
      rx = 1'b1;
      reset_n = 1'b1;
      mcount = 0;
      tick(5);
      send_byte(v, 1'b1, gb, 20);
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
         errors++;
         $display("FAIL postreset_write: got no write, need addr=0 data=7e");
      end else begin
         o = obs_q.pop_front();
         if (o !== e) begin
            errors++;
            $display("FAIL postreset_write: got addr=%0d data=%02h cnt=%0d, need addr=%0d data=%02h cnt=%0d",
                     o.addr, o.data, o.cnt, e.addr, e.data, e.cnt);
         end else $display("post-reset write addr=%0d data=%02h ok", o.addr, o.data);
      end
   endtask

   task automatic test_back_to_back();
      wr_t e, o;
      bit ok;
      int err0 = obs_err;
      int exp0 = exp_err;
      for (int i = 0; i < 24; i++) begin
         ok = ($urandom_range(0, 7) != 0);
         send_byte(8'($urandom), ok, -1, ok ? $urandom_range(0, 60) : $urandom_range(20, 120));
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL random_write: got no write, need addr=%0d data=%02h", e.addr, e.data);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL random_write: got addr=%0d data=%02h cnt=%0d, need addr=%0d data=%02h cnt=%0d",
                        o.addr, o.data, o.cnt, e.addr, e.data, e.cnt);
            end else $display("random write addr=%0d data=%02h ok", o.addr, o.data);
         end
      end
      checks++;
      if (obs_q.size() != 0 || obs_err - err0 != exp_err - exp0 || byte_count !== 13'(mcount)) begin
         errors++;
         $display("FAIL random_totals: got extra=%0d errs=%0d cnt=%0d, need extra=0 errs=%0d cnt=%0d",
                  obs_q.size(), obs_err - err0, byte_count, exp_err - exp0, mcount);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame();
      test_framing_err();
      test_timeout();
      test_reset_mid_byte();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no end of test, need completion within 90000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
